mem_bus_arbiter: RTL and testbench

//  Shares the CPU's single Avalon-MM memory master port between instruction fetch and data (load/store).

---
 rtl/mem_bus_arbiter_if.sv | 48 ++++
 rtl/mem_bus_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Bundles the fetch port, data port and Avalon-MM master port of mem_bus_arbiter.
// The arbiter uses the slave modport; the sequencer/memory side uses master.
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ack;
    logic [DATA_W-1:0] i_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [BE_W-1:0]   d_be;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;

    logic [ADDR_W-1:0] avm_address;
    logic              avm_read;
    logic              avm_write;
    logic [DATA_W-1:0] avm_writedata;
    logic [BE_W-1:0]   avm_byteenable;
    logic [DATA_W-1:0] avm_readdata;
    logic              avm_waitreq;

    logic              active;
    logic              bus_err;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be,
        input  avm_readdata, avm_waitreq,
        output i_ack, i_rdata, d_ack, d_rdata,
        output avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
        output active, bus_err
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be,
        output avm_readdata, avm_waitreq,
        input  i_ack, i_rdata, d_ack, d_rdata,
        input  avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
        input  active, bus_err
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one Avalon-MM master between instruction fetch and data access, one transfer at a time.
// A fetch from address 0 halts the CPU until reset.
module mem_bus_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int WAIT_LIMIT = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    mem_bus_arbiter_if.slave      bus
);
    localparam int BE_W = DATA_W / 8;
    localparam int CW   = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
    localparam logic [CW-1:0] WCNT_MAX = CW'((WAIT_LIMIT > 0) ? WAIT_LIMIT - 1 : 0);

    typedef enum logic [1:0] {IDLE, IBUS, DBUS, HALT} state_t;

    state_t            r_state, w_state;
    logic              r_last_d, w_last_d;
    logic [CW-1:0]     r_wcnt, w_wcnt;
    logic [ADDR_W-1:0] r_addr, w_addr;
    logic              r_rd, w_rd;
    logic              r_wr, w_wr;
    logic [DATA_W-1:0] r_wdata, w_wdata;
    logic [BE_W-1:0]   r_be, w_be;
    logic              r_iack, w_iack;
    logic              r_dack, w_dack;
    logic [DATA_W-1:0] r_irdata, w_irdata;
    logic [DATA_W-1:0] r_drdata, w_drdata;
    logic              r_active, w_active;
    logic              r_err, w_err;

    logic w_i_elig, w_d_elig, w_pick_d;

    // A request still high during its own ack cycle is the old one, not a new one.
    assign w_i_elig = bus.i_req && !r_iack;
    assign w_d_elig = bus.d_req && !r_dack;

    always_comb begin
        w_state  = r_state;
        w_last_d = r_last_d;
        w_wcnt   = r_wcnt;
        w_addr   = r_addr;
        w_rd     = r_rd;
        w_wr     = r_wr;
        w_wdata  = r_wdata;
        w_be     = r_be;
        w_iack   = 1'b0;
        w_dack   = 1'b0;
        w_irdata = r_irdata;
        w_drdata = r_drdata;
        w_active = r_active;
        w_err    = r_err;
        w_pick_d = 1'b0;
        case (r_state)
            IDLE: begin
                w_pick_d = w_d_elig && (!w_i_elig || !r_last_d);
                if (w_pick_d) begin
                    w_state  = DBUS;
                    w_last_d = 1'b1;
                    w_wcnt   = '0;
                    w_addr   = bus.d_addr;
                    w_rd     = !bus.d_we;
                    w_wr     = bus.d_we;
                    w_wdata  = bus.d_wdata;
                    w_be     = bus.d_be;
                end else if (w_i_elig) begin
                    if (bus.i_addr == '0) begin
                        w_state  = HALT;
                        w_active = 1'b0;
                    end else begin
                        w_state  = IBUS;
                        w_last_d = 1'b0;
                        w_wcnt   = '0;
                        w_addr   = bus.i_addr;
                        w_rd     = 1'b1;
                        w_be     = '1;
                    end
                end
            end
            IBUS, DBUS: begin
                if (!bus.avm_waitreq) begin
                    w_rd    = 1'b0;
                    w_wr    = 1'b0;
                    w_wcnt  = '0;
                    w_state = IDLE;
                    if (r_state == IBUS) begin
                        w_irdata = bus.avm_readdata;
                        w_iack   = 1'b1;
                    end else begin
                        if (r_rd) w_drdata = bus.avm_readdata;
                        w_dack = 1'b1;
                    end
                end else if ((WAIT_LIMIT > 0) && (r_wcnt == WCNT_MAX)) begin
                    // Abort: requester gets its ack but keeps its old read data.
                    w_rd    = 1'b0;
                    w_wr    = 1'b0;
                    w_wcnt  = '0;
                    w_state = IDLE;
                    w_err   = 1'b1;
                    if (r_state == IBUS) w_iack = 1'b1;
                    else                 w_dack = 1'b1;
                end else begin
                    w_wcnt = r_wcnt + 1'b1;
                end
            end
            HALT: begin
                w_rd     = 1'b0;
                w_wr     = 1'b0;
                w_active = 1'b0;
            end
            default: w_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_last_d <= 1'b0;
            r_wcnt   <= '0;
            r_addr   <= '0;
            r_rd     <= 1'b0;
            r_wr     <= 1'b0;
            r_wdata  <= '0;
            r_be     <= '0;
            r_iack   <= 1'b0;
            r_dack   <= 1'b0;
            r_irdata <= '0;
            r_drdata <= '0;
            r_active <= 1'b1;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_last_d <= w_last_d;
            r_wcnt   <= w_wcnt;
            r_addr   <= w_addr;
            r_rd     <= w_rd;
            r_wr     <= w_wr;
            r_wdata  <= w_wdata;
            r_be     <= w_be;
            r_iack   <= w_iack;
            r_dack   <= w_dack;
            r_irdata <= w_irdata;
            r_drdata <= w_drdata;
            r_active <= w_active;
            r_err    <= w_err;
        end
    end

    assign bus.avm_address    = r_addr;
    assign bus.avm_read       = r_rd;
    assign bus.avm_write      = r_wr;
    assign bus.avm_writedata  = r_wdata;
    assign bus.avm_byteenable = r_be;
    assign bus.i_ack          = r_iack;
    assign bus.i_rdata        = r_irdata;
    assign bus.d_ack          = r_dack;
    assign bus.d_rdata        = r_drdata;
    assign bus.active         = r_active;
    assign bus.bus_err        = r_err;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with WAIT_LIMIT=4; outputs are sampled 1ns after each rising edge.
module tb_mem_bus_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_LIMIT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        n_chk++; if (bus.active !== 1'b1) begin n_fail++; $display("FAIL rst_active got %b want 1", bus.active); end
        n_chk++; if (bus.avm_read !== 1'b0 || bus.avm_write !== 1'b0) begin n_fail++; $display("FAIL rst_strobes got rd=%b wr=%b want 0 0", bus.avm_read, bus.avm_write); end
        n_chk++; if (bus.avm_byteenable !== 4'h0) begin n_fail++; $display("FAIL rst_be got %h want 0", bus.avm_byteenable); end
        n_chk++; if (bus.avm_address !== 32'h0) begin n_fail++; $display("FAIL rst_addr got %h want 0", bus.avm_address); end
        n_chk++; if (bus.i_ack !== 1'b0 || bus.d_ack !== 1'b0) begin n_fail++; $display("FAIL rst_acks got i=%b d=%b want 0 0", bus.i_ack, bus.d_ack); end
        n_chk++; if (bus.bus_err !== 1'b0) begin n_fail++; $display("FAIL rst_err got %b want 0", bus.bus_err); end
        n_chk++; if (bus.d_rdata !== 32'h0 || bus.i_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata got i=%h d=%h want 0 0", bus.i_rdata, bus.d_rdata); end
        reset = 1'b1;
    endtask

    task automatic test_read();
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h100; bus.d_be = 4'hF;
        bus.avm_waitreq = 1'b0; bus.avm_readdata = 32'hDEADBEEF;
        tick();
        n_chk++; if (bus.avm_read !== 1'b1 || bus.avm_write !== 1'b0) begin n_fail++; $display("FAIL rd_strobe got rd=%b wr=%b want 1 0", bus.avm_read, bus.avm_write); end
        n_chk++; if (bus.avm_address !== 32'h100) begin n_fail++; $display("FAIL rd_addr got %h want 100", bus.avm_address); end
        n_chk++; if (bus.d_ack !== 1'b0) begin n_fail++; $display("FAIL rd_early_ack got %b want 0", bus.d_ack); end
        tick();
        n_chk++; if (bus.d_ack !== 1'b1) begin n_fail++; $display("FAIL rd_ack got %b want 1", bus.d_ack); end
        n_chk++; if (bus.avm_read !== 1'b0) begin n_fail++; $display("FAIL rd_drop got %b want 0", bus.avm_read); end
        n_chk++; if (bus.d_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_data got %h want deadbeef", bus.d_rdata); end
        bus.d_req = 1'b0;
        tick();
        n_chk++; if (bus.d_ack !== 1'b0) begin n_fail++; $display("FAIL rd_ack_pulse got %b want 0", bus.d_ack); end
    endtask

    task automatic test_alternation();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        bus.i_req = 1'b1; bus.i_addr = 32'h40;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h300; bus.d_be = 4'hF;
        bus.avm_waitreq = 1'b0; bus.avm_readdata = 32'hA5A50300;
        tick();
        n_chk++; if (bus.avm_address !== 32'h300 || bus.avm_read !== 1'b1) begin n_fail++; $display("FAIL alt_first_data got addr=%h rd=%b want 300 1", bus.avm_address, bus.avm_read); end
        tick();
        n_chk++; if (bus.d_ack !== 1'b1 || bus.i_ack !== 1'b0) begin n_fail++; $display("FAIL alt_dack got d=%b i=%b want 1 0", bus.d_ack, bus.i_ack); end
        n_chk++; if (bus.d_rdata !== 32'hA5A50300) begin n_fail++; $display("FAIL alt_drdata got %h want a5a50300", bus.d_rdata); end
        bus.avm_readdata = 32'h0BADF00D;
        tick();
        n_chk++; if (bus.avm_address !== 32'h40 || bus.avm_read !== 1'b1) begin n_fail++; $display("FAIL alt_then_fetch got addr=%h rd=%b want 40 1", bus.avm_address, bus.avm_read); end
        n_chk++; if (bus.avm_byteenable !== 4'hF) begin n_fail++; $display("FAIL alt_fetch_be got %h want f", bus.avm_byteenable); end
        bus.d_req = 1'b0;
        tick();
        n_chk++; if (bus.i_ack !== 1'b1 || bus.i_rdata !== 32'h0BADF00D) begin n_fail++; $display("FAIL alt_iack got ack=%b data=%h want 1 0badf00d", bus.i_ack, bus.i_rdata); end
        tick();
        n_chk++; if (bus.avm_read !== 1'b0 || bus.i_ack !== 1'b0) begin n_fail++; $display("FAIL alt_ackcycle_req got rd=%b ack=%b want 0 0", bus.avm_read, bus.i_ack); end
        bus.i_req = 1'b0;
        bus.d_req = 1'b1; bus.d_addr = 32'h304; bus.avm_readdata = 32'h00000304;
        tick();
        tick();
        n_chk++; if (bus.d_ack !== 1'b1 || bus.d_rdata !== 32'h304) begin n_fail++; $display("FAIL alt_solo_data got ack=%b data=%h want 1 304", bus.d_ack, bus.d_rdata); end
        bus.d_req = 1'b0;
        tick();
        bus.i_req = 1'b1; bus.i_addr = 32'h44;
        bus.d_req = 1'b1; bus.d_addr = 32'h308; bus.avm_readdata = 32'h44444444;
        tick();
        n_chk++; if (bus.avm_address !== 32'h44 || bus.avm_read !== 1'b1) begin n_fail++; $display("FAIL alt_fetch_wins got addr=%h rd=%b want 44 1", bus.avm_address, bus.avm_read); end
        tick();
        n_chk++; if (bus.i_ack !== 1'b1 || bus.i_rdata !== 32'h44444444) begin n_fail++; $display("FAIL alt_iack2 got ack=%b data=%h want 1 44444444", bus.i_ack, bus.i_rdata); end
        bus.i_req = 1'b0; bus.avm_readdata = 32'h00000308;
        tick();
        n_chk++; if (bus.avm_address !== 32'h308 || bus.avm_read !== 1'b1) begin n_fail++; $display("FAIL alt_data_after got addr=%h rd=%b want 308 1", bus.avm_address, bus.avm_read); end
        tick();
        n_chk++; if (bus.d_ack !== 1'b1 || bus.d_rdata !== 32'h308) begin n_fail++; $display("FAIL alt_dack2 got ack=%b data=%h want 1 308", bus.d_ack, bus.d_rdata); end
        bus.d_req = 1'b0;
        tick();
    endtask

    task automatic test_write_wait();
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h200; bus.d_wdata = 32'hCAFEF00D; bus.d_be = 4'b0011;
        bus.avm_waitreq = 1'b1; bus.avm_readdata = 32'hFFFFFFFF;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_chk++; if (bus.avm_write !== 1'b1 || bus.avm_read !== 1'b0) begin n_fail++; $display("FAIL wr_held[%0d] got wr=%b rd=%b want 1 0", k, bus.avm_write, bus.avm_read); end
            n_chk++; if (bus.avm_address !== 32'h200 || bus.avm_writedata !== 32'hCAFEF00D || bus.avm_byteenable !== 4'b0011) begin n_fail++; $display("FAIL wr_stable[%0d] got %h %h %b want 200 cafef00d 0011", k, bus.avm_address, bus.avm_writedata, bus.avm_byteenable); end
            n_chk++; if (bus.d_ack !== 1'b0) begin n_fail++; $display("FAIL wr_early_ack[%0d] got %b want 0", k, bus.d_ack); end
        end
        bus.avm_waitreq = 1'b0;
        tick();
        n_chk++; if (bus.avm_write !== 1'b0 || bus.d_ack !== 1'b1) begin n_fail++; $display("FAIL wr_done got wr=%b ack=%b want 0 1", bus.avm_write, bus.d_ack); end
        n_chk++; if (bus.d_rdata !== 32'h308 || bus.bus_err !== 1'b0) begin n_fail++; $display("FAIL wr_side got rdata=%h err=%b want 308 0", bus.d_rdata, bus.bus_err); end
        bus.d_req = 1'b0; bus.d_we = 1'b0;
        tick();
        n_chk++; if (bus.d_ack !== 1'b0 || bus.avm_write !== 1'b0) begin n_fail++; $display("FAIL wr_single_ack got ack=%b wr=%b want 0 0", bus.d_ack, bus.avm_write); end
    endtask

    task automatic test_reset_mid();
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h500; bus.d_wdata = 32'h55; bus.d_be = 4'hF;
        bus.avm_waitreq = 1'b1;
        tick();
        n_chk++; if (bus.avm_write !== 1'b1) begin n_fail++; $display("FAIL rm_start got %b want 1", bus.avm_write); end
        reset = 1'b0;
        tick();
        n_chk++; if (bus.avm_write !== 1'b0 || bus.d_ack !== 1'b0) begin n_fail++; $display("FAIL rm_abort got wr=%b ack=%b want 0 0", bus.avm_write, bus.d_ack); end
        reset = 1'b1;
        bus.i_req = 1'b1; bus.i_addr = 32'h80; bus.avm_waitreq = 1'b0;
        tick();
        n_chk++; if (bus.avm_write !== 1'b1 || bus.avm_address !== 32'h500) begin n_fail++; $display("FAIL rm_data_first got wr=%b addr=%h want 1 500", bus.avm_write, bus.avm_address); end
        tick();
        n_chk++; if (bus.d_ack !== 1'b1 || bus.avm_write !== 1'b0) begin n_fail++; $display("FAIL rm_ack got ack=%b wr=%b want 1 0", bus.d_ack, bus.avm_write); end
        bus.d_req = 1'b0; bus.i_req = 1'b0; bus.d_we = 1'b0;
        tick();
    endtask

    task automatic test_abort();
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h600; bus.d_be = 4'hF;
        bus.avm_waitreq = 1'b1; bus.avm_readdata = 32'h12345678;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_chk++; if (bus.avm_read !== 1'b1 || bus.d_ack !== 1'b0 || bus.bus_err !== 1'b0) begin n_fail++; $display("FAIL ab_wait[%0d] got rd=%b ack=%b err=%b want 1 0 0", k, bus.avm_read, bus.d_ack, bus.bus_err); end
        end
        tick();
        n_chk++; if (bus.avm_read !== 1'b0 || bus.d_ack !== 1'b1) begin n_fail++; $display("FAIL ab_drop got rd=%b ack=%b want 0 1", bus.avm_read, bus.d_ack); end
        n_chk++; if (bus.bus_err !== 1'b1) begin n_fail++; $display("FAIL ab_err got %b want 1", bus.bus_err); end
        n_chk++; if (bus.d_rdata !== 32'h0) begin n_fail++; $display("FAIL ab_rdata got %h want 0", bus.d_rdata); end
        bus.d_req = 1'b0; bus.avm_waitreq = 1'b0;
        tick();
        bus.d_req = 1'b1; bus.d_addr = 32'h604; bus.avm_readdata = 32'h00000604;
        tick();
        tick();
        n_chk++; if (bus.d_ack !== 1'b1 || bus.d_rdata !== 32'h604) begin n_fail++; $display("FAIL ab_next_read got ack=%b data=%h want 1 604", bus.d_ack, bus.d_rdata); end
        n_chk++; if (bus.bus_err !== 1'b1) begin n_fail++; $display("FAIL ab_sticky got %b want 1", bus.bus_err); end
        bus.d_req = 1'b0;
        tick();
    endtask

    task automatic test_halt();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        n_chk++; if (bus.bus_err !== 1'b0) begin n_fail++; $display("FAIL ht_err_clear got %b want 0", bus.bus_err); end
        bus.i_req = 1'b1; bus.i_addr = 32'h0;
        tick();
        n_chk++; if (bus.active !== 1'b0 || bus.avm_read !== 1'b0 || bus.i_ack !== 1'b0) begin n_fail++; $display("FAIL ht_enter got act=%b rd=%b ack=%b want 0 0 0", bus.active, bus.avm_read, bus.i_ack); end
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h700;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_chk++; if (bus.active !== 1'b0 || bus.avm_read !== 1'b0 || bus.avm_write !== 1'b0 || bus.i_ack !== 1'b0 || bus.d_ack !== 1'b0) begin n_fail++; $display("FAIL ht_ignore[%0d] got act=%b rd=%b wr=%b ia=%b da=%b want 0 0 0 0 0", k, bus.active, bus.avm_read, bus.avm_write, bus.i_ack, bus.d_ack); end
        end
        reset = 1'b0;
        tick();
        n_chk++; if (bus.active !== 1'b1 || bus.avm_read !== 1'b0) begin n_fail++; $display("FAIL ht_exit got act=%b rd=%b want 1 0", bus.active, bus.avm_read); end
        reset = 1'b1; bus.i_req = 1'b0; bus.d_req = 1'b0;
        tick();
        n_chk++; if (bus.active !== 1'b1) begin n_fail++; $display("FAIL ht_stay_active got %b want 1", bus.active); end
    endtask

    initial begin
        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_be = '0;
        bus.avm_readdata = '0; bus.avm_waitreq = 1'b0;
        test_reset();
        test_read();
        test_alternation();
        test_write_wait();
        test_reset_mid();
        test_abort();
        test_halt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout simulation did not finish within 100000 ns");
        $fatal(1);
    end
endmodule
